pc_calc: RTL and testbench

PC_CALC -- requirements
Module: pc_calc

---
 rtl/pc_calc.sv | 45 ++++
 tb/tb_pc_calc.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_calc.sv
// Next-PC datapath for a MIPS-style fetch stage: computes PC+4, branch and jump
// targets combinationally and registers the selected next PC.
module pc_calc #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] PC,
   input  logic        PCSrc,
   input  logic        Jump,
   output logic [31:0] NPC,
   output logic [31:0] PC_plus_4,
   output logic [31:0] PC_q
);

   logic [31:0] branch_offset;
   logic [31:0] branch_target;
   logic [31:0] jump_target;

   // Sign-extended word offset; the opcode field is deliberately not decoded here.
   assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign PC_plus_4     = PC + 32'd4;
   assign branch_target = PC_plus_4 + branch_offset;
   assign jump_target   = {PC_plus_4[31:28], instr[25:0], 2'b00};

   // Jump outranks a taken branch when both are asserted.
   always_comb begin
      NPC = PC_plus_4;
      if (Jump) begin
         NPC = jump_target;
      end else if (PCSrc) begin
         NPC = branch_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         PC_q <= RESET_PC;
      end else begin
         PC_q <= NPC;
      end
   end

endmodule

// File: tb/tb_pc_calc.sv
// Directed bench for pc_calc: combinational target selection, wrap and
// alignment corners, and the registered PC loop through reset.
module tb_pc_calc;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic [31:0] pcDrive;
   logic        tiePc;
   logic        PCSrc;
   logic        Jump;
   logic [31:0] NPC;
   logic [31:0] PC_plus_4;
   logic [31:0] PC_q;
   logic [31:0] pcIn;

   int checks = 0;
   int errors = 0;

   // The registered path is exercised by feeding PC_q back as the current PC.
   assign pcIn = tiePc ? PC_q : pcDrive;

   pc_calc #(.RESET_PC(32'h0000_3000)) dut (
      .clk       (clk),
      .reset     (reset),
      .instr     (instr),
      .PC        (pcIn),
      .PCSrc     (PCSrc),
      .Jump      (Jump),
      .NPC       (NPC),
      .PC_plus_4 (PC_plus_4),
      .PC_q      (PC_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [31:0] pcVal, input logic [31:0] instrVal,
                                input logic srcVal, input logic jumpVal);
      pcDrive = pcVal;
      instr   = instrVal;
      PCSrc   = srcVal;
      Jump    = jumpVal;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      tiePc = 1'b0;
      applyStimulus(32'h0000_3000, 32'h0, 1'b0, 1'b0);
      @(negedge clk);

      // Sequential fall-through
      checkOutput("seq_pc4", PC_plus_4, 32'h0000_3004);
      checkOutput("seq_npc", NPC, 32'h0000_3004);

      // Branch taken and not taken
      applyStimulus(32'h0000_3000, 32'h1022_0002, 1'b1, 1'b0);
      checkOutput("br_taken", NPC, 32'h0000_300C);
      applyStimulus(32'h0000_3000, 32'h1022_0002, 1'b0, 1'b0);
      checkOutput("br_not_taken", NPC, 32'h0000_3004);

      // Jump, and jump priority over branch
      applyStimulus(32'h0000_3000, 32'h0800_0C04, 1'b0, 1'b1);
      checkOutput("jump", NPC, 32'h0000_3010);
      applyStimulus(32'h0000_3000, 32'h0800_0C04, 1'b1, 1'b1);
      checkOutput("jump_prio", NPC, 32'h0000_3010);

      // Opcode bits must not influence the target
      applyStimulus(32'h0000_3000, 32'hFC00_0C04, 1'b0, 1'b1);
      checkOutput("jump_opcode_ignored", NPC, 32'h0000_3010);

      // Negative branch offset
      applyStimulus(32'h0000_3000, 32'h1000_FFFF, 1'b1, 1'b0);
      checkOutput("br_negative", NPC, 32'h0000_3000);
      applyStimulus(32'h0000_3000, 32'h1000_8000, 1'b1, 1'b0);
      checkOutput("br_most_negative", NPC, 32'hFFFE_3004);

      // Jump keeps upper nibble of PC+4
      applyStimulus(32'h9000_0000, 32'h0800_0C04, 1'b0, 1'b1);
      checkOutput("jump_region", NPC, 32'h9000_3010);
      applyStimulus(32'h8FFF_FFFC, 32'h0800_0C04, 1'b0, 1'b1);
      checkOutput("jump_region_carry", NPC, 32'h9000_3010);

      // Wrap-around of PC+4
      applyStimulus(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
      checkOutput("wrap_pc4", PC_plus_4, 32'h0000_0000);
      checkOutput("wrap_npc", NPC, 32'h0000_0000);

      // Misaligned PC bits pass straight through
      applyStimulus(32'h0000_3001, 32'h1000_0001, 1'b1, 1'b0);
      checkOutput("misaligned_pc4", PC_plus_4, 32'h0000_3005);
      checkOutput("misaligned_br", NPC, 32'h0000_3009);

      // Registered path: reset, then free-run with PC fed back
      applyStimulus(32'h0000_3000, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tiePc = 1'b1;
      tick();
      checkOutput("reset_pcq", PC_q, 32'h0000_3000);
      checkOutput("reset_no_comb_effect", NPC, 32'h0000_3004);
      @(negedge clk);
      reset = 1'b0;
      tick();
      checkOutput("run_pcq_1", PC_q, 32'h0000_3004);
      tick();
      checkOutput("run_pcq_2", PC_q, 32'h0000_3008);

      // Jump loaded into the register
      @(negedge clk);
      applyStimulus(32'h0, 32'h0800_0C04, 1'b0, 1'b1);
      tick();
      checkOutput("run_pcq_jump", PC_q, 32'h0000_3010);

      // Reassert reset mid-run
      @(negedge clk);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("rereset_pcq", PC_q, 32'h0000_3000);
      @(negedge clk);
      reset = 1'b0;
      tick();
      checkOutput("post_rereset_pcq", PC_q, 32'h0000_3004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
